eio_responder: RTL and testbench

//  Responder (slave) end of the MEM-stage external I/O bus (EIO_intf.slave). Decodes a BASE_ADDR window,

---
 rtl/eio_responder.sv | 202 ++++++++++++++++++++
 tb/tb_eio_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/eio_responder.sv
// eio_responder: responder end of the MEM-stage external I/O bus, serving scratch, GPIO and (optionally) timer registers.
// Define EIO_TIMER_EN to build the 64-bit mtime/mtimecmp timer; otherwise its offsets fault and timer_irq is tied low.
module eio_responder #(
  parameter int               PC_SZ       = 32,
  parameter int               RSZ         = 32,
  parameter logic [PC_SZ-1:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int               WAIT_STATES = 1,
  parameter int               GPIO_W      = 8
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              eio_req,
  input  logic [PC_SZ-1:0]  eio_addr,
  input  logic              eio_rd,
  input  logic              eio_wr,
  input  logic [RSZ-1:0]    eio_wr_data,
  output logic              eio_ack,
  output logic              eio_ack_fault,
  output logic [RSZ-1:0]    eio_ack_data,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

  typedef enum logic [2:0] {
    REG_SCRATCH0 = 3'd0,
    REG_SCRATCH1 = 3'd1,
    REG_GPIO_OUT = 3'd2,
    REG_GPIO_IN  = 3'd3,
    REG_MTIME_LO = 3'd4,
    REG_MTIME_HI = 3'd5,
    REG_MTCMP_LO = 3'd6,
    REG_MTCMP_HI = 3'd7
  } reg_e;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e             state_q, state_d;
  logic   [3:0]       cnt_q, cnt_d;

  reg_e               cap_reg;
  logic               cap_rd, cap_wr, cap_fault;
  logic   [RSZ-1:0]   cap_wdata;

  reg_e               req_reg;
  logic               in_window, misaligned, bad_dir, ro_write, timer_off, req_fault;

  logic               commit, wr_en;
  logic   [RSZ-1:0]   rdata;
  logic   [RSZ-1:0]   scratch0, scratch1;
  logic   [GPIO_W-1:0] gpio_meta, gpio_sync;

  // Request decode, evaluated on the live bus so the fault is known at capture time.
  always_comb begin
    req_reg    = reg_e'(eio_addr[4:2]);
    in_window  = (eio_addr[PC_SZ-1:5] == BASE_ADDR[PC_SZ-1:5]);
    misaligned = |eio_addr[1:0];
    bad_dir    = (eio_rd == eio_wr);
    ro_write   = eio_wr && (req_reg == REG_GPIO_IN);
`ifdef EIO_TIMER_EN
    timer_off  = 1'b0;
`else
    timer_off  = eio_addr[4];
`endif
    req_fault  = !in_window || misaligned || bad_dir || ro_write || timer_off;
  end

  // NOTE: every variable gets a default before the case so no path holds an old value (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (eio_req) begin
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all flops see pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request once; WAIT and ACK work only from this copy.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cap_reg   <= REG_SCRATCH0;
      cap_rd    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_fault <= 1'b0;
      cap_wdata <= '0;
    end else if (state_q == ST_IDLE && eio_req) begin
      cap_reg   <= req_reg;
      cap_rd    <= eio_rd;
      cap_wr    <= eio_wr;
      cap_fault <= req_fault;
      cap_wdata <= eio_wr_data;
    end
  end

  assign commit = (state_q == ST_ACK);
  assign wr_en  = commit && cap_wr && !cap_fault;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      gpio_meta <= '0;
      gpio_sync <= '0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
    end
  end

`ifdef EIO_TIMER_EN
  logic [31:0] mtime_lo, mtime_hi, mtcmp_lo, mtcmp_hi;
  logic        lo_wr, hi_wr;

  assign lo_wr = wr_en && (cap_reg == REG_MTIME_LO);
  assign hi_wr = wr_en && (cap_reg == REG_MTIME_HI);

  // A bus write to either half wins over the free-running increment; a LO write suppresses the carry.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mtime_lo  <= '0;
      mtime_hi  <= '0;
      mtcmp_lo  <= '1;
      mtcmp_hi  <= '1;
      timer_irq <= 1'b0;
    end else begin
      mtime_lo <= lo_wr ? cap_wdata[31:0] : mtime_lo + 32'd1;
      if (hi_wr)
        mtime_hi <= cap_wdata[31:0];
      else if (!lo_wr && mtime_lo == '1)
        mtime_hi <= mtime_hi + 32'd1;
      if (wr_en && cap_reg == REG_MTCMP_LO) mtcmp_lo <= cap_wdata[31:0];
      if (wr_en && cap_reg == REG_MTCMP_HI) mtcmp_hi <= cap_wdata[31:0];
      timer_irq <= ({mtime_hi, mtime_lo} >= {mtcmp_hi, mtcmp_lo});
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (cap_reg)
      REG_SCRATCH0: rdata = scratch0;
      REG_SCRATCH1: rdata = scratch1;
      REG_GPIO_OUT: rdata[GPIO_W-1:0] = gpio_out;
      REG_GPIO_IN:  rdata[GPIO_W-1:0] = gpio_sync;
`ifdef EIO_TIMER_EN
      REG_MTIME_LO: rdata[31:0] = mtime_lo;
      REG_MTIME_HI: rdata[31:0] = mtime_hi;
      REG_MTCMP_LO: rdata[31:0] = mtcmp_lo;
      REG_MTCMP_HI: rdata[31:0] = mtcmp_hi;
`endif
      default:      rdata = '0;
    endcase
  end

  // Writes commit and read data is registered on the same edge that raises ack.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      eio_ack       <= 1'b0;
      eio_ack_fault <= 1'b0;
      eio_ack_data  <= '0;
      scratch0      <= '0;
      scratch1      <= '0;
      gpio_out      <= '0;
    end else begin
      eio_ack       <= commit;
      eio_ack_fault <= commit && cap_fault;
      eio_ack_data  <= (commit && cap_rd && !cap_fault) ? rdata : '0;
      if (wr_en) begin
        case (cap_reg)
          REG_SCRATCH0: scratch0 <= cap_wdata;
          REG_SCRATCH1: scratch1 <= cap_wdata;
          REG_GPIO_OUT: gpio_out <= cap_wdata[GPIO_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eio_responder.sv
// Directed bench for eio_responder: a WAIT_STATES=1 instance for most traffic and a WAIT_STATES=0 instance for back-to-back reads.
`timescale 1ns/1ps
module tb_eio_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic clk_in = 1'b0;
  logic reset_in;
  always #5 clk_in = ~clk_in;

  logic        a_req, a_rd, a_wr, a_ack, a_fault, a_irq;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [7:0]  a_gin, a_gout;
  logic        b_req, b_rd, b_wr, b_ack, b_fault, b_irq;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [7:0]  b_gin, b_gout;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  eio_responder #(.WAIT_STATES(1)) u_dut_a (
    .clk_in(clk_in), .reset_in(reset_in),
    .eio_req(a_req), .eio_addr(a_addr), .eio_rd(a_rd), .eio_wr(a_wr), .eio_wr_data(a_wdata),
    .eio_ack(a_ack), .eio_ack_fault(a_fault), .eio_ack_data(a_rdata),
    .gpio_in(a_gin), .gpio_out(a_gout), .timer_irq(a_irq)
  );

  eio_responder #(.WAIT_STATES(0)) u_dut_b (
    .clk_in(clk_in), .reset_in(reset_in),
    .eio_req(b_req), .eio_addr(b_addr), .eio_rd(b_rd), .eio_wr(b_wr), .eio_wr_data(b_wdata),
    .eio_ack(b_ack), .eio_ack_fault(b_fault), .eio_ack_data(b_rdata),
    .gpio_in(b_gin), .gpio_out(b_gout), .timer_irq(b_irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      b_req = req; b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata;
    end
  endtask

  // One complete transaction; entered and left 1ns after a rising edge.
  task automatic xact(input bit sel, input string tag, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_fault);
    int   n;
    logic ack;
    exp_t e;
    sb_q.push_back('{data: exp_data, fault: exp_fault});
    drive(sel, 1'b1, rd, wr, addr, wdata);
    n = 0;
    do begin
      @(posedge clk_in); #1;
      n++;
      ack = sel ? b_ack : a_ack;
    end while (!ack && n < 40);
    e = sb_q.pop_front();
    check({tag, " latency"}, 64'(n), sel ? 64'd2 : 64'd3);
    check({tag, " fault"}, sel ? b_fault : a_fault, e.fault);
    check({tag, " data"}, sel ? b_rdata : a_rdata, e.data);
    drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk_in); #1;
    check({tag, " single ack"}, sel ? b_ack : a_ack, 64'd0);
  endtask

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_data [3];

  initial begin
    int   n, acks, last, idx;
    exp_t e;

    reset_in = 1'b1;
    a_gin = 8'h00;
    b_gin = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk_in);
    #1;
    check("reset ack", a_ack, 64'd0);
    check("reset fault", a_fault, 64'd0);
    check("reset data", a_rdata, 64'd0);
    check("reset gpio_out", a_gout, 64'd0);
    check("reset irq", a_irq, 64'd0);
    reset_in = 1'b0;

    // Basic write then read with one wait state.
    xact(1'b0, "wr scratch0", 1'b0, 1'b1, BASE + 32'h00, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xact(1'b0, "rd scratch0", 1'b1, 1'b0, BASE + 32'h00, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Faulting requests must not touch any register.
    xact(1'b0, "flt out of window hi", 1'b1, 1'b0, BASE + 32'h20, 32'h0, 32'h0, 1'b1);
    xact(1'b0, "flt out of window lo", 1'b1, 1'b0, BASE - 32'h04, 32'h0, 32'h0, 1'b1);
    xact(1'b0, "flt misaligned", 1'b1, 1'b0, BASE + 32'h02, 32'h0, 32'h0, 1'b1);
    xact(1'b0, "flt wr gpio_in", 1'b0, 1'b1, BASE + 32'h0C, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xact(1'b0, "flt rd and wr", 1'b1, 1'b1, BASE + 32'h00, 32'h1111_1111, 32'h0, 1'b1);
    xact(1'b0, "flt neither", 1'b0, 1'b0, BASE + 32'h00, 32'h2222_2222, 32'h0, 1'b1);
    xact(1'b0, "flt misaligned wr", 1'b0, 1'b1, BASE + 32'h01, 32'h3333_3333, 32'h0, 1'b1);
    xact(1'b0, "rd scratch0 after faults", 1'b1, 1'b0, BASE + 32'h00, 32'h0, 32'hDEAD_BEEF, 1'b0);
    check("gpio_out after faults", a_gout, 64'd0);

    // GPIO output truncation and synchronised input.
    xact(1'b0, "wr gpio_out", 1'b0, 1'b1, BASE + 32'h08, 32'h0000_01A5, 32'h0, 1'b0);
    check("gpio_out value", a_gout, 64'hA5);
    xact(1'b0, "rd gpio_out", 1'b1, 1'b0, BASE + 32'h08, 32'h0, 32'h0000_00A5, 1'b0);
    a_gin = 8'h3C;
    repeat (2) @(posedge clk_in);
    #1;
    xact(1'b0, "rd gpio_in", 1'b1, 1'b0, BASE + 32'h0C, 32'h0, 32'h0000_003C, 1'b0);
    xact(1'b0, "wr scratch1", 1'b0, 1'b1, BASE + 32'h04, 32'h5555_AAAA, 32'h0, 1'b0);
    xact(1'b0, "rd scratch1", 1'b1, 1'b0, BASE + 32'h04, 32'h0, 32'h5555_AAAA, 1'b0);

`ifdef EIO_TIMER_EN
    xact(1'b0, "wr mtimecmp_hi", 1'b0, 1'b1, BASE + 32'h1C, 32'h0000_0001, 32'h0, 1'b0);
    xact(1'b0, "wr mtimecmp_lo", 1'b0, 1'b1, BASE + 32'h18, 32'h0000_0002, 32'h0, 1'b0);
    xact(1'b0, "wr mtime_hi", 1'b0, 1'b1, BASE + 32'h14, 32'h0000_0000, 32'h0, 1'b0);
    xact(1'b0, "wr mtime_lo", 1'b0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFE, 32'h0, 1'b0);
    check("irq before compare", a_irq, 64'd0);
    n = 0;
    do begin
      @(posedge clk_in); #1;
      n++;
    end while (!a_irq && n < 20);
    check("irq rise cycle", 64'(n), 64'd4);
    xact(1'b0, "rd mtime_hi after wrap", 1'b1, 1'b0, BASE + 32'h14, 32'h0, 32'h0000_0001, 1'b0);
    check("irq held", a_irq, 64'd1);
    xact(1'b0, "wr mtimecmp_hi 2", 1'b0, 1'b1, BASE + 32'h1C, 32'h0000_0002, 32'h0, 1'b0);
    check("irq cleared", a_irq, 64'd0);
`else
    xact(1'b0, "flt timer rd", 1'b1, 1'b0, BASE + 32'h10, 32'h0, 32'h0, 1'b1);
    xact(1'b0, "flt timer wr", 1'b0, 1'b1, BASE + 32'h1C, 32'h0000_0002, 32'h0, 1'b1);
    check("irq tied low", a_irq, 64'd0);
`endif

    // Zero wait states: preload, then three reads with req held throughout.
    xact(1'b1, "b wr scratch0", 1'b0, 1'b1, BASE + 32'h00, 32'h1111_0000, 32'h0, 1'b0);
    xact(1'b1, "b wr scratch1", 1'b0, 1'b1, BASE + 32'h04, 32'h2222_0000, 32'h0, 1'b0);
    xact(1'b1, "b wr gpio_out", 1'b0, 1'b1, BASE + 32'h08, 32'h0000_005A, 32'h0, 1'b0);
    b2b_addr = '{BASE + 32'h00, BASE + 32'h04, BASE + 32'h08};
    b2b_data = '{32'h1111_0000, 32'h2222_0000, 32'h0000_005A};
    for (int i = 0; i < 3; i++) sb_q.push_back('{data: b2b_data[i], fault: 1'b0});
    idx  = 0;
    acks = 0;
    last = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, b2b_addr[0], 32'h0);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk_in); #1;
      if (b_ack) begin
        acks++;
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("b2b data", b_rdata, e.data);
          check("b2b fault", b_fault, e.fault);
        end
        if (acks > 1) check("b2b spacing", 64'(cyc - last), 64'd2);
        last = cyc;
        idx++;
        if (idx < 3) drive(1'b1, 1'b1, 1'b1, 1'b0, b2b_addr[idx], 32'h0);
        else         drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    check("b2b ack count", 64'(acks), 64'd3);
    sb_q.delete();

    // Reset during the wait state of a write; the held req becomes a fresh read.
    drive(1'b0, 1'b1, 1'b0, 1'b1, BASE + 32'h04, 32'h0000_1234);
    @(posedge clk_in); #1;
    reset_in = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, BASE + 32'h04, 32'h0);
    @(posedge clk_in); #1;
    check("no ack in reset 1", a_ack, 64'd0);
    @(posedge clk_in); #1;
    check("no ack in reset 2", a_ack, 64'd0);
    reset_in = 1'b0;
    sb_q.push_back('{data: 32'h0, fault: 1'b0});
    n = 0;
    do begin
      @(posedge clk_in); #1;
      n++;
    end while (!a_ack && n < 40);
    e = sb_q.pop_front();
    check("post-reset latency", 64'(n), 64'd3);
    check("post-reset scratch1", a_rdata, e.data);
    check("post-reset fault", a_fault, e.fault);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk_in); #1;
    check("post-reset single ack", a_ack, 64'd0);
    check("post-reset gpio_out", a_gout, 64'd0);
    check("post-reset irq", a_irq, 64'd0);
    xact(1'b0, "post-reset scratch0", 1'b1, 1'b0, BASE + 32'h00, 32'h0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
